// File: rtl/ann_layer_mac.sv
// Time-multiplexed fully-connected ANN layer: one shared signed MAC computes N_OUT
// fixed-point dot products plus bias. Define ANN_RELU_EN to clamp negative results to 0.
`timescale 1ns/1ps
module ann_layer_mac #(
  parameter int DW    = 32,
  parameter int FRAC  = 16,
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int AW    = $clog2(N_OUT*(N_IN+1))
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    w_we,
  input  logic [AW-1:0]                           w_addr,
  input  logic [DW-1:0]                           w_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DW-1:0]                           in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DW-1:0]                           out_data,
  output logic [((N_OUT>1)?$clog2(N_OUT):1)-1:0]  out_idx,
  output logic                                    out_last,
  output logic                                    busy,
  output logic [1:0]                              dbg_state
);
  localparam int NW   = N_OUT*(N_IN+1);
  localparam int IW   = $clog2(N_IN+1);
  localparam int JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int ACCW = 2*DW + IW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_EMIT} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]          i_cnt;
  logic [JW-1:0]          j_cnt;
  logic signed [ACCW-1:0] acc;
  logic [DW-1:0]          x_buf [1<<IW];
  logic [DW-1:0]          wmem  [1<<AW];

  logic                   last_x, term_done, last_j, in_hs;
  logic [AW-1:0]          rd_addr;
  logic [DW-1:0]          w_rd, x_rd, sat;
  logic signed [2*DW-1:0] xa, wa, prod, term;
  logic signed [ACCW-1:0] sum;
  logic [ACCW-DW:0]       hi;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holding valid keeps its data stable until that edge.
  assign last_x    = (i_cnt == IW'(N_IN-1));
  assign term_done = (i_cnt == IW'(N_IN));
  assign last_j    = (j_cnt == JW'(N_OUT-1));
  assign in_hs     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
        if (in_valid) state_nxt = last_x ? S_MAC : S_LOAD;
      end
      S_LOAD: begin
        in_ready = !rst;
        if (in_valid && last_x) state_nxt = S_MAC;
      end
      S_MAC: if (term_done) state_nxt = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = last_j ? S_IDLE : S_MAC;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign out_idx   = j_cnt;
  assign out_last  = out_valid && last_j;
  assign dbg_state = state;

  // Weight store and input buffer carry no reset: weights persist across resets.
  always_ff @(posedge clk) begin
    if (w_we && state == S_IDLE && int'(w_addr) < NW) wmem[w_addr] <= w_data;
    if (in_hs) x_buf[i_cnt] <= in_data;
  end

  assign rd_addr = AW'(int'(j_cnt) * (N_IN+1) + int'(i_cnt));
  assign w_rd    = wmem[rd_addr];
  assign x_rd    = x_buf[i_cnt];
  assign xa      = {{DW{x_rd[DW-1]}}, x_rd};
  assign wa      = {{DW{w_rd[DW-1]}}, w_rd};
  assign prod    = xa * wa;
  assign term    = prod >>> FRAC;
  // In the bias cycle w_rd addresses the bias word of the current neuron.
  assign sum     = acc + {{(ACCW-DW){w_rd[DW-1]}}, w_rd};
  assign hi      = sum[ACCW-1:DW-1];

  always_comb begin
    if (&hi || ~|hi)   sat = sum[DW-1:0];
    else if (sum[ACCW-1]) sat = {1'b1, {(DW-1){1'b0}}};
    else                  sat = {1'b0, {(DW-1){1'b1}}};
`ifdef ANN_RELU_EN
    if (sat[DW-1]) sat = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt    <= '0;
      j_cnt    <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_hs) begin
            if (last_x) begin
              i_cnt <= '0;
              j_cnt <= '0;
              acc   <= '0;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (!term_done) begin
            acc   <= acc + {{IW{term[2*DW-1]}}, term};
            i_cnt <= i_cnt + 1'b1;
          end else begin
            out_data <= sat;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            i_cnt <= '0;
            acc   <= '0;
            j_cnt <= last_j ? '0 : j_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ann_layer_mac.md
# ann_layer_mac

Parametrised, time-multiplexed fully-connected ANN layer: buffers an `N_IN`-element input vector, computes `N_OUT` signed fixed-point dot products plus bias on one shared MAC, and emits results one neuron at a time over a valid/ready stream. It is the next-generation layer stage in the network pipeline. It replaces fixed two-neuron layers with a configurable neuron count, a runtime-loadable weight store and back-pressure on both sides.

## Interface
- `DW`, 32: data/weight width, signed two's complement.
- `FRAC`, 16: fractional bits (Q(DW-FRAC).FRAC).
- `N_IN`, 2: inputs per neuron, ≥1.
- `N_OUT`, 2: neurons in layer, ≥1.
- `AW`, `$clog2(N_OUT*(N_IN+1))`: weight address width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `w_we` in 1: weight write strobe.
- `w_addr` in AW: weight address; neuron j, input i at `j*(N_IN+1)+i`; `i=N_IN` is bias.
- `w_data` in DW: weight/bias value.
- `in_valid` in 1: input element valid.
- `in_ready` out 1: layer accepts input element.
- `in_data` in DW: input element, presented in order x0..x(N_IN-1).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_data` out DW: neuron result.
- `out_idx` out `$clog2(N_OUT)` (min 1): neuron index of `out_data`.
- `out_last` out 1: high with the result of neuron N_OUT-1.
- `busy` out 1: high in any state except IDLE.

## Operation
- States: IDLE, LOAD, MAC, EMIT.
- IDLE: `in_ready=1`. The first `in_valid` handshake stores x0 and moves to LOAD, or to MAC if N_IN=1. Weight writes are honoured only in IDLE. `w_we` in other states is ignored.
- LOAD: `in_ready=1`. Each handshake stores the next element. The handshake that stores x(N_IN-1) moves to MAC with j=0, i=0, acc=0.
- MAC: one term per cycle, `acc += (x[i]*w[j][i]) >>> FRAC`.
  - Product is full 2·DW signed, shifted arithmetically. Accumulator is 2·DW+`$clog2(N_IN+1)` bits, no wrap.
  - After term N_IN-1, one extra cycle adds the sign-extended bias. The result is then saturated to DW (max `2^(DW-1)-1`, min `-2^(DW-1)`), registered into `out_data`, and the state moves to EMIT.
- EMIT: `out_valid=1`. `out_data`, `out_idx` and `out_last` stay stable until `out_ready`.
  - On handshake with j<N_OUT-1: j++, acc=0, i=0, back to MAC.
  - On handshake with j=N_OUT-1: back to IDLE.
- `in_ready=0` in MAC and EMIT. The input buffer is held for all neurons.
- Weights persist across vectors and are not cleared by reset; contents are undefined until written.

## Timing
- Reset values: `in_ready=0` during reset, then 1 in IDLE the first cycle after release. `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`, `busy=0`, state IDLE, counters 0.
- `rst` asserted mid-operation aborts immediately. The partial vector and accumulator are discarded, with no output.
- Per-neuron latency: N_IN+1 cycles from MAC entry to `out_valid` high.
- Latency with `out_ready` tied high: last input handshake to first `out_valid` is N_IN+1 cycles. A full vector occupies N_OUT·(N_IN+2) cycles after load.
- `out_valid` never drops without a handshake. `out_ready` low stalls the layer indefinitely.
- A write to `w_addr` ≥ N_OUT·(N_IN+1) is ignored.
- `w_we` and an `in_valid` handshake in the same IDLE cycle: both take effect, and the write is visible to the MAC.

## Configuration
- `ANN_RELU_EN` defined: after saturation, a negative result is replaced by 0. The result keeps the same latency.
- Undefined: the raw saturated result is emitted.

## Test plan
- Reset and weight load, N_IN=2, N_OUT=2, FRAC=16:
  - Stimulus: load w0=(1.0, 2.0, bias 0.5) and w1=(-1.0, 0.5, bias 0). Stream x=(1.0, 1.0) with `out_ready=1`.
  - Required: `out_data`=0x00038000 idx0, then 0xFFFF8000 idx1 with `out_last=1`. With `ANN_RELU_EN` defined, idx1 is 0.
- Back-pressure:
  - Stimulus: hold `out_ready=0` for 10 cycles in EMIT.
  - Required: `out_valid`, `out_data` and `out_idx` stay stable, `in_ready=0`, and the next neuron starts only after the handshake.
- Saturation:
  - Stimulus: weights 0x7FFF0000 on both inputs, x=(0x7FFF0000, 0x7FFF0000).
  - Required: `out_data`=0x7FFFFFFF. Negating one operand set gives 0x80000000, or 0 under ReLU.
- Mid-operation reset:
  - Stimulus: assert `rst` asynchronously during MAC of neuron 1.
  - Required: `out_valid=0` and `busy=0` with no clock edge. A fresh vector afterwards produces correct results and stored weights are retained.
- Ignored writes:
  - Stimulus: issue `w_we` during MAC and at an out-of-range address.
  - Required: results are unchanged versus the golden model.
- Parameter sweep:
  - Stimulus: N_IN=5, N_OUT=3, random in/out stalls, 200 vectors.
  - Required: results match a bit-accurate reference model, and `out_last` is high exactly once per vector.
